wall_probe_sequencer: RTL and testbench

- Time-shares a single wall-map ROM read port to compute all four ball-movement permissions: Up, Down, Left and Right blocked flags.
- Replaces four parallel row lookups with one pipelined 18-read sweep per check.
- Sits between the ball motion logic, which issues start once per frame, and wall_rom.
- The wall ROM is driven with a row address and returns one 640-bit row, 1 = wall.

---
 rtl/wall_probe_sequencer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_wall_probe_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wall_probe_sequencer.sv
// wall_probe_sequencer
// Uses one wall-ROM read port to work out whether the ball may move up, down,
// left or right. One accepted start runs a fixed sweep of BALL_SIZE+2 row reads:
// the row above the ball, the row below it, then every row the ball covers.
// The four blocked flags are produced from that sweep.
// Ports:
//   Clk, Reset        clock and asynchronous active-high reset
//   start             check request, taken only while busy=0
//   BallX, BallY      ball top-left corner, latched on the accepted start
//   rom_addr, rom_en  registered ROM row address and read strobe
//   rom_data          ROM row, valid ROM_LAT cycles after address/strobe
//   busy, done        check in progress / one-cycle completion pulse
//   Up/Down/Left/Right blocked flags, updated in the done cycle and held otherwise
module wall_probe_sequencer #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int BALL_SIZE = 16,
  parameter int ROM_LAT   = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                start,
  input  logic [9:0]          BallX,
  input  logic [9:0]          BallY,
  output logic [9:0]          rom_addr,
  output logic                rom_en,
  input  logic [SCREEN_W-1:0] rom_data,
  output logic                busy,
  output logic                done,
  output logic                Up,
  output logic                Down,
  output logic                Left,
  output logic                Right
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int NSLOT  = BALL_SIZE + 2;
  localparam int PIPE_D = (ROM_LAT == 0) ? 1 : ROM_LAT;
  localparam int IW     = $clog2(SCREEN_W);

  logic [1:0] state_q, state_d;
  logic [4:0] slot_q, slot_d;
  logic [1:0] lat_q, lat_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [9:0] addr_q, addr_d;
  logic       en_q, en_d;
  logic       iss_vld_q, iss_vld_d;
  logic [4:0] iss_slot_q, iss_slot_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic       up_acc_q, up_acc_d, dn_acc_q, dn_acc_d;
  logic       lf_acc_q, lf_acc_d, rt_acc_q, rt_acc_d;
  logic       up_q, up_d, dn_q, dn_d, lf_q, lf_d, rt_q, rt_d;
  logic [PIPE_D-1:0] pv_q, pe_q;
  logic [4:0]        ps_q [PIPE_D];
  logic       cap_vld, cap_en;
  logic [4:0] cap_slot;
  logic [11:0] row_sel;

  // Row for a slot, 11 bits wide so Y-1 and Y+n never wrap; bit 11 = row in range.
  function automatic logic [11:0] slot_row(input logic [4:0] s, input logic [9:0] y);
    logic [10:0] r;
    logic        v;
    if (s == 5'd0) begin
      r = {1'b0, y} - 11'd1;
      v = (y != 10'd0) && (r < 11'(SCREEN_H));
    end else if (s == 5'd1) begin
      r = {1'b0, y} + 11'(BALL_SIZE);
      v = (r < 11'(SCREEN_H));
    end else begin
      r = {1'b0, y} + {6'd0, s} - 11'd2;
      v = (r < 11'(SCREEN_H));
    end
    return {v, r};
  endfunction

  // Columns past the right screen edge read as wall.
  function automatic logic bit_at(input logic [SCREEN_W-1:0] data, input logic [10:0] idx);
    if (idx >= 11'(SCREEN_W)) return 1'b1;
    else return data[idx[IW-1:0]];
  endfunction

  function automatic logic win_or(input logic [SCREEN_W-1:0] data, input logic [9:0] x);
    logic o;
    o = 1'b0;
    for (int i = 0; i < BALL_SIZE; i++) o = o | bit_at(data, {1'b0, x} + 11'(i));
    return o;
  endfunction

  // Tag of the slot whose data is on rom_data this cycle.
  always_comb begin
    if (ROM_LAT == 0) begin
      cap_vld  = iss_vld_q;
      cap_en   = en_q;
      cap_slot = iss_slot_q;
    end else begin
      cap_vld  = pv_q[PIPE_D-1];
      cap_en   = pe_q[PIPE_D-1];
      cap_slot = ps_q[PIPE_D-1];
    end
  end

  // Sequencer: state, slot/drain counters and the registered ROM request.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    lat_d      = lat_q;
    x_d        = x_q;
    y_d        = y_q;
    addr_d     = 10'd0;
    en_d       = 1'b0;
    iss_vld_d  = 1'b0;
    iss_slot_d = 5'd0;
    row_sel    = 12'd0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d        = BallX;
          y_d        = BallY;
          state_d    = S_ISSUE;
          slot_d     = 5'd0;
          row_sel    = slot_row(5'd0, BallY);
          iss_vld_d  = 1'b1;
          iss_slot_d = 5'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (slot_q == 5'(NSLOT - 1)) begin
          slot_d  = 5'd0;
          lat_d   = 2'd0;
          state_d = (ROM_LAT == 0) ? S_DONE : S_DRAIN;
        end else begin
          slot_d     = slot_q + 5'd1;
          row_sel    = slot_row(slot_q + 5'd1, y_q);
          iss_vld_d  = 1'b1;
          iss_slot_d = slot_q + 5'd1;
        end
      end
      S_DRAIN: begin
        if (lat_q == 2'(ROM_LAT - 1)) begin
          state_d = S_DONE;
          lat_d   = 2'd0;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Out-of-range rows still take their slot, but with no read.
    en_d   = iss_vld_d & row_sel[11];
    addr_d = en_d ? row_sel[9:0] : 10'd0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Accumulators: cleared on accept, folded with ROM data in capture cycles.
  always_comb begin
    up_acc_d = up_acc_q;
    dn_acc_d = dn_acc_q;
    lf_acc_d = lf_acc_q;
    rt_acc_d = rt_acc_q;
    if (state_q == S_IDLE && start) begin
      up_acc_d = 1'b0;
      dn_acc_d = 1'b0;
      lf_acc_d = (BallX == 10'd0);
      rt_acc_d = ({1'b0, BallX} + 11'(BALL_SIZE)) >= 11'(SCREEN_W);
    end else if (cap_vld) begin
      if (cap_slot == 5'd0) begin
        up_acc_d = up_acc_q | (cap_en ? win_or(rom_data, x_q) : 1'b1);
      end else if (cap_slot == 5'd1) begin
        dn_acc_d = dn_acc_q | (cap_en ? win_or(rom_data, x_q) : 1'b1);
      end else if (cap_en) begin
        lf_acc_d = lf_acc_q | ((x_q != 10'd0) & bit_at(rom_data, {1'b0, x_q} - 11'd1));
        rt_acc_d = rt_acc_q | bit_at(rom_data, {1'b0, x_q} + 11'(BALL_SIZE));
      end else begin
        lf_acc_d = lf_acc_q;
      end
    end else begin
      up_acc_d = up_acc_q;
    end
    // Outputs move only on the edge that enters the done cycle.
    if (state_d == S_DONE) begin
      up_d = up_acc_d;
      dn_d = dn_acc_d;
      lf_d = lf_acc_d;
      rt_d = rt_acc_d;
    end else begin
      up_d = up_q;
      dn_d = dn_q;
      lf_d = lf_q;
      rt_d = rt_q;
    end
  end

  // State, request, slot-tag pipeline and result registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      slot_q     <= 5'd0;
      lat_q      <= 2'd0;
      x_q        <= 10'd0;
      y_q        <= 10'd0;
      addr_q     <= 10'd0;
      en_q       <= 1'b0;
      iss_vld_q  <= 1'b0;
      iss_slot_q <= 5'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      up_acc_q   <= 1'b0;
      dn_acc_q   <= 1'b0;
      lf_acc_q   <= 1'b0;
      rt_acc_q   <= 1'b0;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
      lf_q       <= 1'b0;
      rt_q       <= 1'b0;
      pv_q       <= '0;
      pe_q       <= '0;
      for (int i = 0; i < PIPE_D; i++) ps_q[i] <= 5'd0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      lat_q      <= lat_d;
      x_q        <= x_d;
      y_q        <= y_d;
      addr_q     <= addr_d;
      en_q       <= en_d;
      iss_vld_q  <= iss_vld_d;
      iss_slot_q <= iss_slot_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      up_acc_q   <= up_acc_d;
      dn_acc_q   <= dn_acc_d;
      lf_acc_q   <= lf_acc_d;
      rt_acc_q   <= rt_acc_d;
      up_q       <= up_d;
      dn_q       <= dn_d;
      lf_q       <= lf_d;
      rt_q       <= rt_d;
      pv_q[0]    <= iss_vld_q;
      pe_q[0]    <= en_q;
      ps_q[0]    <= iss_slot_q;
      for (int i = 1; i < PIPE_D; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        ps_q[i] <= ps_q[i-1];
      end
    end
  end

  assign rom_addr = addr_q;
  assign rom_en   = en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign Up       = up_q;
  assign Down     = dn_q;
  assign Left     = lf_q;
  assign Right    = rt_q;

endmodule

// File: tb/tb_wall_probe_sequencer.sv
// Bench for wall_probe_sequencer: one instance with ROM_LAT=1 and one with
// ROM_LAT=3 share stimulus; each has its own ROM model fed from a sparse wall list.
// Expected flags and done cycles are queued at start and popped on done.
module tb_wall_probe_sequencer;

  logic         Clk, Reset, start;
  logic [9:0]   BallX, BallY;
  logic [9:0]   addr1, addr3;
  logic         en1, en3, busy1, busy3, done1, done3;
  logic         up1, dn1, lf1, rt1, up3, dn3, lf3, rt3;
  logic [639:0] rd1, r3a, r3b, r3c;

  int wr[$];
  int wc[$];
  logic [35:0] q1[$];
  logic [35:0] q3[$];
  logic [35:0] e1, e3;
  logic [3:0]  last1, last3;
  int cyc, n_checks, n_fail;

  wall_probe_sequencer #(.ROM_LAT(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .start(start), .BallX(BallX), .BallY(BallY),
    .rom_addr(addr1), .rom_en(en1), .rom_data(rd1), .busy(busy1), .done(done1),
    .Up(up1), .Down(dn1), .Left(lf1), .Right(rt1));

  wall_probe_sequencer #(.ROM_LAT(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .start(start), .BallX(BallX), .BallY(BallY),
    .rom_addr(addr3), .rom_en(en3), .rom_data(r3c), .busy(busy3), .done(done3),
    .Up(up3), .Down(dn3), .Left(lf3), .Right(rt3));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [639:0] row_bits(input int r);
    logic [639:0] v;
    v = '0;
    for (int k = 0; k < wr.size(); k++) if (wr[k] == r) v[wc[k]] = 1'b1;
    return v;
  endfunction

  function automatic logic is_wall(input int r, input int c);
    if (c >= 640) return 1'b1;
    for (int k = 0; k < wr.size(); k++) if (wr[k] == r && wc[k] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_flags(input int x, input int y);
    logic u, d, l, r;
    u = (y == 0);
    d = (y + 16 >= 480);
    l = (x == 0);
    r = (x + 16 >= 640);
    for (int i = 0; i < 16; i++) begin
      if (y > 0 && is_wall(y - 1, x + i)) u = 1'b1;
      if (y + 16 < 480 && is_wall(y + 16, x + i)) d = 1'b1;
      if (y + i < 480) begin
        if (x > 0 && is_wall(y + i, x - 1)) l = 1'b1;
        if (is_wall(y + i, x + 16)) r = 1'b1;
      end
    end
    return {u, d, l, r};
  endfunction

  // ROM models: disabled reads return all-ones garbage.
  always @(posedge Clk) begin
    rd1 <= en1 ? row_bits(int'(addr1)) : {640{1'b1}};
    r3a <= en3 ? row_bits(int'(addr3)) : {640{1'b1}};
    r3b <= r3a;
    r3c <= r3b;
  end

  always @(negedge Clk) begin
    if (!Reset) begin
      if (done1) begin
        if (q1.size() == 0) check_eq("done1_spurious", 32'd1, 32'd0);
        else begin
          e1 = q1.pop_front();
          check_eq("done1_cycle", cyc, e1[31:0]);
          check_eq("flags1", {28'd0, up1, dn1, lf1, rt1}, {28'd0, e1[35:32]});
        end
        last1 = {up1, dn1, lf1, rt1};
      end else check_eq("hold1", {28'd0, up1, dn1, lf1, rt1}, {28'd0, last1});
    end
  end

  always @(negedge Clk) begin
    if (!Reset) begin
      if (done3) begin
        if (q3.size() == 0) check_eq("done3_spurious", 32'd1, 32'd0);
        else begin
          e3 = q3.pop_front();
          check_eq("done3_cycle", cyc, e3[31:0]);
          check_eq("flags3", {28'd0, up3, dn3, lf3, rt3}, {28'd0, e3[35:32]});
        end
        last3 = {up3, dn3, lf3, rt3};
      end else check_eq("hold3", {28'd0, up3, dn3, lf3, rt3}, {28'd0, last3});
    end
  end

  task automatic set_wall(input int r, input int c);
    wr.delete();
    wc.delete();
    if (r >= 0) begin
      wr.push_back(r);
      wc.push_back(c);
    end
  endtask

  // mode: 0 plain, 1 timing/address trace, 2 slot0 no-read, 3 slot1 no-read,
  // 4 ignored re-start, 5 reset mid-check.
  task automatic do_check(input int x, input int y, input int mode);
    int e0;
    logic [3:0] f;
    @(negedge Clk);
    e0 = cyc + 1;
    f = exp_flags(x, y);
    BallX = 10'(x);
    BallY = 10'(y);
    start = 1'b1;
    q1.push_back({f, 32'(e0 + 19)});
    q3.push_back({f, 32'(e0 + 21)});
    for (int j = 0; j < 40; j++) begin
      @(negedge Clk);
      start = 1'b0;
      case (mode)
        1: begin
          check_eq("busy1", {31'd0, busy1}, {31'd0, (j <= 19)});
          check_eq("done1", {31'd0, done1}, {31'd0, (j == 19)});
          check_eq("busy3", {31'd0, busy3}, {31'd0, (j <= 21)});
          check_eq("done3", {31'd0, done3}, {31'd0, (j == 21)});
          if (j < 18) begin
            check_eq("addr1", {22'd0, addr1}, (j == 0) ? 32'd99 : (j == 1) ? 32'd116 : 32'(100 + j - 2));
            check_eq("en1", {31'd0, en1}, 32'd1);
          end else check_eq("en1_idle", {31'd0, en1}, 32'd0);
        end
        2: if (j == 0) begin
          check_eq("slot0_en1", {31'd0, en1}, 32'd0);
          check_eq("slot0_en3", {31'd0, en3}, 32'd0);
          check_eq("slot0_addr1", {22'd0, addr1}, 32'd0);
        end
        3: if (j == 1) begin
          check_eq("slot1_en1", {31'd0, en1}, 32'd0);
          check_eq("slot1_en3", {31'd0, en3}, 32'd0);
        end
        4: if (j == 4) begin
          BallX = 10'd300;
          start = 1'b1;
        end
        5: begin
          if (j == 9) begin
            #1;
            Reset = 1'b1;
            #1;
            check_eq("rst_busy", {30'd0, busy1, busy3}, 32'd0);
            check_eq("rst_flags", {24'd0, up1, dn1, lf1, rt1, up3, dn3, lf3, rt3}, 32'd0);
            q1.delete();
            q3.delete();
            last1 = 4'd0;
            last3 = 4'd0;
          end
          if (j == 10) Reset = 1'b0;
        end
        default: ;
      endcase
      if (j >= 22 && q1.size() == 0 && q3.size() == 0) break;
    end
    check_eq("drain1", q1.size(), 32'd0);
    check_eq("drain3", q3.size(), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    last1    = 4'd0;
    last3    = 4'd0;
    Reset    = 1'b1;
    start    = 1'b0;
    BallX    = 10'd0;
    BallY    = 10'd0;
    set_wall(-1, 0);
    repeat (3) @(negedge Clk);
    check_eq("reset_ctl", {26'd0, busy1, done1, en1, busy3, done3, en3}, 32'd0);
    check_eq("reset_addr", {12'd0, addr1, addr3}, 32'd0);
    check_eq("reset_flags", {24'd0, up1, dn1, lf1, rt1, up3, dn3, lf3, rt3}, 32'd0);
    Reset = 1'b0;

    do_check(100, 100, 1);          // empty map, full trace
    set_wall(116, 115);
    do_check(100, 100, 0);          // Down
    set_wall(116, 116);
    do_check(100, 100, 0);          // just outside the window
    set_wall(-1, 0);
    do_check(0, 0, 2);              // Up + Left from screen edges
    do_check(624, 464, 3);          // Right + Down from screen edges
    set_wall(105, 99);
    do_check(100, 100, 4);          // Left; second start ignored
    do_check(0, 200, 5);            // reset mid-check
    set_wall(65, 199);
    do_check(200, 50, 0);           // wall at row Y+15, column X-1
    set_wall(49, 205);
    do_check(200, 50, 0);           // back-to-back, now Up only
    set_wall(300, 150);
    do_check(134, 300, 0);          // Right via column X+16
    set_wall(-1, 0);
    do_check(630, 479, 0);          // window past right edge, Y+16 past bottom

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
